// File: rtl/triangle_pkg.sv
// Shared types and constants for the triangle scheduler slice.
package triangle_pkg;

  localparam int unsigned CW_DEF   = 3;
  localparam int unsigned PT_CNT_W = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD0,
    S_LOAD1,
    S_LOAD2,
    S_WAIT_BUSY,
    S_RUN,
    S_DONE
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  always_comb begin
    int unsigned cand;
    grant = '0;
    idx   = '0;
    cand  = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = (32'(ptr) + i) % NREQ;
      if (advance && (grant == '0) && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/triangle_scheduler.sv
// Shares one triangle rasterizer core between NREQ requesters: round-robin grant,
// three-cycle vertex feed, tagged point forwarding and per-triangle point count.
module triangle_scheduler
  import triangle_pkg::*;
#(
  parameter  int unsigned NREQ     = 4,
  parameter  int unsigned CW       = CW_DEF,
  parameter  int unsigned BUSY_TMO = 8,
  localparam int unsigned IW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*3*CW-1:0] vtx_x,
  input  logic [NREQ*3*CW-1:0] vtx_y,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic [PT_CNT_W-1:0]  pt_count,
  output logic                 nt,
  output logic [CW-1:0]        xi,
  output logic [CW-1:0]        yi,
  input  logic                 busy,
  input  logic                 po,
  input  logic [CW-1:0]        xo,
  input  logic [CW-1:0]        yo,
  output logic                 pt_valid,
  output logic [CW-1:0]        pt_x,
  output logic [CW-1:0]        pt_y,
  output logic [IW-1:0]        pt_id
);

  localparam int unsigned   TW       = $clog2(BUSY_TMO + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TMO - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

  state_t                state, state_nxt;
  logic [IW-1:0]         rr_ptr;
  logic [3*CW-1:0]       vx, vy;
  logic [PT_CNT_W-1:0]   pt_cnt;
  logic [TW-1:0]         tmo_cnt;
  logic                  err_flag;
  logic [NREQ-1:0]       arb_grant;
  logic [IW-1:0]         arb_idx;
  logic                  arb_any;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req),
    .advance (state == S_IDLE),
    .ptr     (rr_ptr),
    .grant   (arb_grant),
    .idx     (arb_idx)
  );

  assign arb_any = |arb_grant;

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    done      = '0;
    err       = 1'b0;
    pt_count  = '0;
    nt        = 1'b0;
    xi        = '0;
    yi        = '0;
    case (state)
      S_IDLE:  if (arb_any) state_nxt = S_LOAD0;
      S_LOAD0: begin
        state_nxt  = S_LOAD1;
        gnt[pt_id] = 1'b1;
        nt         = 1'b1;
        xi         = vx[0 +: CW];
        yi         = vy[0 +: CW];
      end
      S_LOAD1: begin
        state_nxt = S_LOAD2;
        xi        = vx[CW +: CW];
        yi        = vy[CW +: CW];
      end
      S_LOAD2: begin
        state_nxt = S_WAIT_BUSY;
        xi        = vx[2*CW +: CW];
        yi        = vy[2*CW +: CW];
      end
      S_WAIT_BUSY: begin
        if (busy)                     state_nxt = S_RUN;
        else if (tmo_cnt == TMO_LAST) state_nxt = S_DONE;
      end
      S_RUN:   if (!busy) state_nxt = S_DONE;
      S_DONE: begin
        state_nxt   = S_IDLE;
        done[pt_id] = 1'b1;
        err         = err_flag;
        pt_count    = pt_cnt;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      pt_id    <= '0;
      vx       <= '0;
      vy       <= '0;
      pt_cnt   <= '0;
      tmo_cnt  <= '0;
      err_flag <= 1'b0;
      pt_valid <= 1'b0;
      pt_x     <= '0;
      pt_y     <= '0;
    end else begin
      state    <= state_nxt;
      pt_valid <= 1'b0;
      case (state)
        S_IDLE: if (arb_any) begin
          pt_id    <= arb_idx;
          rr_ptr   <= (arb_idx == LAST_IDX) ? '0 : arb_idx + IW'(1);
          vx       <= vtx_x[int'(arb_idx)*3*CW +: 3*CW];
          vy       <= vtx_y[int'(arb_idx)*3*CW +: 3*CW];
          pt_cnt   <= '0;
          tmo_cnt  <= '0;
          err_flag <= 1'b0;
        end
        // Points arriving before busy rises still belong to this triangle.
        S_WAIT_BUSY, S_RUN: begin
          if (po) begin
            pt_valid <= 1'b1;
            pt_x     <= xo;
            pt_y     <= yo;
            if (pt_cnt != '1) pt_cnt <= pt_cnt + PT_CNT_W'(1);
          end
          if (state == S_WAIT_BUSY && !busy) begin
            if (tmo_cnt == TMO_LAST) err_flag <= 1'b1;
            else                     tmo_cnt  <= tmo_cnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
